demux_stream: RTL and testbench
===============================

DEMUX_STREAM -- requirements
Module: demux_stream

Interface
REQ-001 SHALL have parameter SELECT_WIDTH, default 5: selector width in bits.
REQ-002 SHALL have parameter DATA_WIDTH, default 5: payload width is 2**DATA_WIDTH bits.
REQ-003 SHALL have parameter NUM_OUT, default 32: number of outputs, legal range 1..2**SELECT_WIDTH.
REQ-004 SHALL have port clk_i, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_ni, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port data_i, input, 2**DATA_WIDTH bits: input payload.
REQ-007 SHALL have port selector_i, input, SELECT_WIDTH bits: destination index of the input beat.
REQ-008 SHALL have port valid_i, input, 1 bit: input beat valid.
REQ-009 SHALL have port ready_o, output, 1 bit: registered input ready.
REQ-010 SHALL have port out_o, output, unpacked array [NUM_OUT] of 2**DATA_WIDTH bits: per-output payload.
REQ-011 SHALL have port valid_o, output, NUM_OUT bits: per-output valid.
REQ-012 SHALL have port ready_i, input, NUM_OUT bits: per-output ready.
REQ-013 SHALL have port drop_o, output, 1 bit: one-cycle pulse when a beat is discarded.
REQ-014 SHALL have port drop_cnt_o, output, 16 bits: saturating count of discarded beats.

Function
REQ-015 SHALL accept a beat when valid_i && ready_o at a rising edge (push).
REQ-016 SHALL retire the head beat when its valid_o[sel] && ready_i[sel] at a rising edge (pop).
REQ-017 SHALL buffer beats in a 2-entry store, head plus skid; state machine EMPTY, BUSY (head only), FULL (head and skid).
REQ-018 SHALL make these transitions:
- EMPTY+push -> BUSY.
- BUSY+push, no pop -> FULL, with the beat held in skid.
- BUSY+pop, no push -> EMPTY.
- BUSY+push+pop -> BUSY, with the head loaded from the input.
- FULL+pop -> BUSY, with the head loaded from skid.
- Otherwise the state holds.
REQ-019 SHALL register ready_o: it is 1 in EMPTY and BUSY and 0 in FULL, and it is the next-state value, so no push is lost.
REQ-020 SHALL give one cycle of latency: a beat pushed at edge N asserts valid_o[sel] from the cycle after edge N.
REQ-021 SHALL assert at most one valid_o bit at a time, namely the bit of the head's stored selector.
REQ-022 SHALL drive out_o[k] with the head payload when valid_o[k] is 1 and with zero otherwise.
REQ-023 SHALL hold the head payload and valid_o stable until pop; a low ready_i stalls with no loss.
REQ-024 SHALL deliver beats in acceptance order regardless of destination.
REQ-025 SHALL discard a pushed beat with selector_i >= NUM_OUT: no state change, drop_o = 1 for the next cycle, drop_cnt_o incremented.
REQ-026 SHALL saturate drop_cnt_o at 16'hFFFF.
REQ-027 SHALL ignore ready_i bits of non-selected outputs.

Reset
REQ-028 SHALL, while rst_ni = 0, immediately force: state EMPTY, ready_o 0, valid_o 0, out_o 0, drop_o 0, drop_cnt_o 0.
REQ-029 SHALL raise ready_o at the first rising edge after rst_ni deasserts.
REQ-030 SHALL discard buffered beats on reset mid-transfer; they are not replayed.

Structure
REQ-031 SHALL place the state enum (EMPTY/BUSY/FULL) and DROP_CNT_WIDTH = 16 in the shared package demux_stream_pkg.
REQ-032 SHALL implement the 2-entry head/skid store as sub-module skid_buffer_2, with data+selector as payload and a valid/ready handshake on both sides.

Verification
REQ-033 SHALL cover single beat: push 32'hDEADBEEF to sel 7 with all ready_i = 1 -> valid_o = 1<<7 and out_o[7] = 32'hDEADBEEF for exactly one cycle, one cycle after the push.
REQ-034 SHALL cover back-pressure: ready_i = 0, push to sel 3 then sel 9 -> ready_o = 0 after the second push; raise ready_i -> sel 3 delivered, then sel 9, in order; ready_o = 1 again.
REQ-035 SHALL cover full throughput: continuous valid_i with ready_i all 1 and sel cycling 0..31 -> one beat per cycle delivered, ready_o never 0.
REQ-036 SHALL cover out-of-range: NUM_OUT = 20, push sel 25 -> no valid_o, drop_o pulse, drop_cnt_o = 1; preload the counter to 16'hFFFF and drop once more -> it stays at 16'hFFFF.
REQ-037 SHALL cover reset mid-operation: in FULL, assert rst_ni = 0 -> all outputs zero without a clock edge; after release, ready_o = 1 at the first edge and no stale beat appears.

Source files
------------

// File: rtl/demux_stream_pkg.sv
// Shared types and constants for the demux_stream slice.
// Holds the buffer state encoding, the drop-counter width and its saturating increment.
package demux_stream_pkg;

    localparam int DROP_CNT_WIDTH = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_e;

    function automatic logic [DROP_CNT_WIDTH-1:0] sat_inc(input logic [DROP_CNT_WIDTH-1:0] v);
        return (&v) ? v : v + DROP_CNT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/skid_buffer_2.sv
// Two-entry head/skid store with valid/ready on both sides.
// in_ready_o is registered from the next state, so the skid entry always has room for a push.
module skid_buffer_2
    import demux_stream_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_valid_o,
    input  logic             out_ready_i
);

    state_e           state_q, state_d;
    logic             ready_q;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             push;
    logic             pop;

    assign push = in_valid_i && ready_q;
    assign pop  = out_valid_o && out_ready_i;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= EMPTY;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != FULL);
        end
    end

    // NOTE: payload registers carry no reset; they are only observed while the state marks them valid.
    always_ff @(posedge clk_i) begin
        head_q <= head_d;
        skid_q <= skid_d;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        unique case (state_q)
            EMPTY: begin
                if (push) begin
                    state_d = BUSY;
                    head_d  = in_data_i;
                end
            end
            BUSY: begin
                if (push && !pop) begin
                    state_d = FULL;
                    skid_d  = in_data_i;
                end else if (push && pop) begin
                    head_d = in_data_i;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    state_d = BUSY;
                    head_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        in_ready_o  = ready_q;
        out_valid_o = (state_q != EMPTY);
        out_data_o  = head_q;
    end

endmodule

// File: rtl/demux_stream.sv
// Stream demultiplexer: buffers beats in a head/skid store and presents the head on its selected output.
// Beats addressed past NUM_OUT are discarded and counted with a saturating counter.
module demux_stream
    import demux_stream_pkg::*;
#(
    parameter int SELECT_WIDTH = 5,
    parameter int DATA_WIDTH   = 5,
    parameter int NUM_OUT      = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [2**DATA_WIDTH-1:0]  data_i,
    input  logic [SELECT_WIDTH-1:0]   selector_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    output logic [2**DATA_WIDTH-1:0]  out_o [NUM_OUT],
    output logic [NUM_OUT-1:0]        valid_o,
    input  logic [NUM_OUT-1:0]        ready_i,
    output logic                      drop_o,
    output logic [DROP_CNT_WIDTH-1:0] drop_cnt_o
);

    localparam int PAYLOAD_W = 2**DATA_WIDTH;
    localparam int ENTRY_W   = SELECT_WIDTH + PAYLOAD_W;

    logic                      in_range;
    logic                      buf_in_valid;
    logic                      buf_out_valid;
    logic                      buf_out_ready;
    logic [ENTRY_W-1:0]        buf_out_data;
    logic [SELECT_WIDTH-1:0]   head_sel;
    logic [PAYLOAD_W-1:0]      head_data;
    logic                      drop_q, drop_d;
    logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

    assign in_range     = 32'(selector_i) < NUM_OUT;
    assign buf_in_valid = valid_i && in_range;

    skid_buffer_2 #(
        .WIDTH(ENTRY_W)
    ) u_skid (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_data_i   ({selector_i, data_i}),
        .in_valid_i  (buf_in_valid),
        .in_ready_o  (ready_o),
        .out_data_o  (buf_out_data),
        .out_valid_o (buf_out_valid),
        .out_ready_i (buf_out_ready)
    );

    assign head_sel  = buf_out_data[ENTRY_W-1 -: SELECT_WIDTH];
    assign head_data = buf_out_data[PAYLOAD_W-1:0];

    always_comb begin
        valid_o = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            valid_o[k] = buf_out_valid && (head_sel == SELECT_WIDTH'(k));
            out_o[k]   = valid_o[k] ? head_data : '0;
        end
    end

    // Only the selected output's ready can retire the head.
    assign buf_out_ready = |(valid_o & ready_i);

    always_comb begin
        drop_d     = valid_i && ready_o && !in_range;
        drop_cnt_d = drop_d ? sat_inc(drop_cnt_q) : drop_cnt_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drop_q     <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            drop_q     <= drop_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_o     = drop_q;
    assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_demux_stream.sv
// Directed bench for demux_stream: a full 32-output instance and a 20-output instance for range drops.
module tb_demux_stream;
    import demux_stream_pkg::*;

    localparam int SW = 5;
    localparam int DW = 5;
    localparam int PW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [PW-1:0] data_a;
    logic [SW-1:0] sel_a;
    logic          valid_a;
    logic          ready_a;
    logic [PW-1:0] out_a [32];
    logic [31:0]   vout_a;
    logic [31:0]   rdy_in_a;
    logic          drop_a;
    logic [15:0]   cnt_a;

    logic [PW-1:0] data_b;
    logic [SW-1:0] sel_b;
    logic          valid_b;
    logic          ready_b;
    logic [PW-1:0] out_b [20];
    logic [19:0]   vout_b;
    logic [19:0]   rdy_in_b;
    logic          drop_b;
    logic [15:0]   cnt_b;

    int n_checks = 0;
    int n_err    = 0;

    demux_stream #(.SELECT_WIDTH(SW), .DATA_WIDTH(DW), .NUM_OUT(32)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .data_i(data_a), .selector_i(sel_a), .valid_i(valid_a),
        .ready_o(ready_a), .out_o(out_a), .valid_o(vout_a), .ready_i(rdy_in_a),
        .drop_o(drop_a), .drop_cnt_o(cnt_a)
    );

    demux_stream #(.SELECT_WIDTH(SW), .DATA_WIDTH(DW), .NUM_OUT(20)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .data_i(data_b), .selector_i(sel_b), .valid_i(valid_b),
        .ready_o(ready_b), .out_o(out_b), .valid_o(vout_b), .ready_i(rdy_in_b),
        .drop_o(drop_b), .drop_cnt_o(cnt_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        data_a = '0; sel_a = '0; valid_a = 1'b0; rdy_in_a = '0;
        data_b = '0; sel_b = '0; valid_b = 1'b0; rdy_in_b = '0;

        // Reset state
        #3;
        check("rst_ready_a", 32'(ready_a), 32'h0);
        check("rst_vout_a", vout_a, 32'h0);
        check("rst_drop_a", 32'(drop_a), 32'h0);
        check("rst_cnt_a", 32'(cnt_a), 32'h0);
        check("rst_ready_b", 32'(ready_b), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rel_ready_a", 32'(ready_a), 32'h1);
        check("rel_ready_b", 32'(ready_b), 32'h1);

        // Single beat
        rdy_in_a = '1;
        data_a = 32'hDEADBEEF; sel_a = 5'd7; valid_a = 1'b1;
        tick();
        valid_a = 1'b0;
        check("single_vout", vout_a, 32'h0000_0080);
        check("single_out7", out_a[7], 32'hDEADBEEF);
        check("single_out6", out_a[6], 32'h0);
        tick();
        check("single_gone", vout_a, 32'h0);
        check("single_out7_zero", out_a[7], 32'h0);
        check("single_ready", 32'(ready_a), 32'h1);

        // Back-pressure
        rdy_in_a = '0;
        data_a = 32'h3333_3333; sel_a = 5'd3; valid_a = 1'b1;
        tick();
        check("bp_ready1", 32'(ready_a), 32'h1);
        check("bp_vout1", vout_a, 32'h0000_0008);
        data_a = 32'h9999_9999; sel_a = 5'd9;
        tick();
        valid_a = 1'b0;
        check("bp_ready_full", 32'(ready_a), 32'h0);
        check("bp_vout_head", vout_a, 32'h0000_0008);
        check("bp_out3", out_a[3], 32'h3333_3333);
        check("bp_out9_zero", out_a[9], 32'h0);
        rdy_in_a = 32'h0000_0200;
        tick();
        check("bp_stall_vout", vout_a, 32'h0000_0008);
        check("bp_stall_out3", out_a[3], 32'h3333_3333);
        check("bp_stall_ready", 32'(ready_a), 32'h0);
        rdy_in_a = '1;
        tick();
        check("bp_second_vout", vout_a, 32'h0000_0200);
        check("bp_out9", out_a[9], 32'h9999_9999);
        check("bp_ready_again", 32'(ready_a), 32'h1);
        tick();
        check("bp_empty", vout_a, 32'h0);

        // Full throughput, selector sweeping every output
        valid_a = 1'b1;
        for (int i = 0; i < 32; i++) begin
            sel_a  = SW'(i);
            data_a = 32'hA000_0000 + 32'(i);
            tick();
            check($sformatf("tp_ready_%0d", i), 32'(ready_a), 32'h1);
            check($sformatf("tp_vout_%0d", i), vout_a, 32'h1 << i);
            check($sformatf("tp_out_%0d", i), out_a[i], 32'hA000_0000 + 32'(i));
        end
        valid_a = 1'b0;
        tick();
        check("tp_drain", vout_a, 32'h0);

        // Out-of-range drops on the 20-output instance
        rdy_in_b = '1;
        data_b = 32'h2525_2525; sel_b = 5'd25; valid_b = 1'b1;
        tick();
        check("oor_vout", 32'(vout_b), 32'h0);
        check("oor_drop", 32'(drop_b), 32'h1);
        check("oor_cnt1", 32'(cnt_b), 32'h1);
        check("oor_ready", 32'(ready_b), 32'h1);
        data_b = 32'h1919_1919; sel_b = 5'd19;
        tick();
        check("edge19_vout", 32'(vout_b), 32'h0008_0000);
        check("edge19_out", out_b[19], 32'h1919_1919);
        check("edge19_nodrop", 32'(drop_b), 32'h0);
        check("edge19_cnt", 32'(cnt_b), 32'h1);
        data_b = 32'h2020_2020; sel_b = 5'd20;
        tick();
        check("edge20_drop", 32'(drop_b), 32'h1);
        check("edge20_cnt", 32'(cnt_b), 32'h2);
        check("edge20_vout", 32'(vout_b), 32'h0);
        valid_b = 1'b0;
        tick();
        check("drop_pulse_end", 32'(drop_b), 32'h0);
        check("cnt_hold", 32'(cnt_b), 32'h2);

        force dut_b.drop_cnt_q = 16'hFFFF;
        #1;
        release dut_b.drop_cnt_q;
        sel_b = 5'd25; valid_b = 1'b1;
        tick();
        valid_b = 1'b0;
        check("sat_drop", 32'(drop_b), 32'h1);
        check("sat_cnt", 32'(cnt_b), 32'hFFFF);
        tick();
        check("sat_cnt_hold", 32'(cnt_b), 32'hFFFF);

        // Reset while FULL
        rdy_in_a = '0;
        data_a = 32'h5555_5555; sel_a = 5'd5; valid_a = 1'b1;
        tick();
        data_a = 32'h6666_6666; sel_a = 5'd6;
        tick();
        valid_a = 1'b0;
        check("mid_full_ready", 32'(ready_a), 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 32'(ready_a), 32'h0);
        check("mid_rst_vout", vout_a, 32'h0);
        check("mid_rst_out5", out_a[5], 32'h0);
        check("mid_rst_cnt_b", 32'(cnt_b), 32'h0);
        tick();
        check("mid_rst_held", vout_a, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("mid_rel_ready", 32'(ready_a), 32'h1);
        check("mid_rel_vout", vout_a, 32'h0);
        rdy_in_a = '1;
        tick();
        check("mid_no_stale", vout_a, 32'h0);
        check("mid_no_stale_out6", out_a[6], 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
